// File: rtl/truth_table_sweeper.sv
// Steps a 4-input function through all 16 vectors and captures its 16-bit truth table.
// Optional self-check against EXPECTED is enabled by defining SWEEP_CHECK_EN.
// The table output is named tbl because table is a reserved word.
module truth_table_sweeper #(
  parameter int unsigned HOLD_CYCLES = 20
`ifdef SWEEP_CHECK_EN
  ,
  parameter logic [15:0] EXPECTED    = 16'h0000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] tbl
`ifdef SWEEP_CHECK_EN
  ,
  output logic        pass,
  output logic        fail
`endif
);

  typedef enum logic [1:0] {StIdle, StDrive, StFinish} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] tbl_q, tbl_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    tbl_d   = tbl_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDrive;
          idx_d   = 4'd0;
          hold_d  = 8'd0;
          tbl_d   = 16'h0000;
        end
      end
      StDrive: begin
        hold_d = hold_q + 8'd1;
        // f has had HOLD_CYCLES-1 cycles to settle on the last hold cycle
        if (hold_q == HoldLast) begin
          tbl_d[idx_q] = f;
          hold_d       = 8'd0;
          if (idx_q == 4'd15) begin
            state_d = StFinish;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 4'd0;
      hold_q  <= 8'd0;
      tbl_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tbl_q   <= tbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {a, b, c, d} = idx_q;
  assign idx  = idx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tbl  = tbl_q;

`ifdef SWEEP_CHECK_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;

  // Verdict uses tbl_d so the final vector's sample is included
  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (state_q == StIdle && start) begin
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else if (state_q == StDrive && state_d == StFinish) begin
      pass_d = (tbl_d == EXPECTED);
      fail_d = (tbl_d != EXPECTED);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (HOLD_CYCLES 20 and 1) driving model functions.
module tb_truth_table_sweeper;

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic        f0, f1;
  logic        a0, b0, c0, d0, a1, b1, c1, d1;
  logic [3:0]  idx0, idx1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] tbl0, tbl1;
  logic        pass0, fail0, pass1, fail1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mode0 = 0;
  int   mode1 = 1;
  int   dones0 = 0;
  int   dones1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  function automatic logic fmodel(input int mode, input logic [3:0] v);
    case (mode)
      0:       return ^v;
      1:       return 1'b1;
      2:       return v[3] & v[2];
      3:       return v[0];
      default: return v[3];
    endcase
  endfunction

  always_comb f0 = fmodel(mode0, {a0, b0, c0, d0});
  always_comb f1 = fmodel(mode1, {a1, b1, c1, d1});

  truth_table_sweeper #(
    .HOLD_CYCLES(20)
`ifdef SWEEP_CHECK_EN
    , .EXPECTED(16'h6996)
`endif
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .f(f0),
    .a(a0), .b(b0), .c(c0), .d(d0), .idx(idx0),
    .busy(busy0), .done(done0), .tbl(tbl0)
`ifdef SWEEP_CHECK_EN
    , .pass(pass0), .fail(fail0)
`endif
  );

  truth_table_sweeper #(
    .HOLD_CYCLES(1)
`ifdef SWEEP_CHECK_EN
    , .EXPECTED(16'hFFFF)
`endif
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .idx(idx1),
    .busy(busy1), .done(done1), .tbl(tbl1)
`ifdef SWEEP_CHECK_EN
    , .pass(pass1), .fail(fail1)
`endif
  );

`ifndef SWEEP_CHECK_EN
  assign {pass0, fail0, pass1, fail1} = 4'b0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("abcd0==idx0", {28'd0, a0, b0, c0, d0}, {28'd0, idx0});
      if (done0) begin
        dones0++;
        n_cmp++;
        if (q0.size() == 0) begin
          n_bad++;
          $display("FAIL done0 with empty scoreboard: tbl %0h", tbl0);
        end else begin
          e0 = q0.pop_front();
          check("tbl0 at done", tbl0, e0.tbl);
`ifdef SWEEP_CHECK_EN
          check("pass0", pass0, e0.pass);
          check("fail0", fail0, !e0.pass);
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("abcd1==idx1", {28'd0, a1, b1, c1, d1}, {28'd0, idx1});
      if (done1) begin
        dones1++;
        n_cmp++;
        if (q1.size() == 0) begin
          n_bad++;
          $display("FAIL done1 with empty scoreboard: tbl %0h", tbl1);
        end else begin
          e1 = q1.pop_front();
          check("tbl1 at done", tbl1, e1.tbl);
`ifdef SWEEP_CHECK_EN
          check("pass1", pass1, e1.pass);
          check("fail1", fail1, !e1.pass);
`endif
        end
      end
    end
  end

  // Full sweep on dut0; optionally re-pulses start when idx0 reaches poke
  task automatic run0(input int mode, input logic [15:0] et, input logic ep, input int poke);
    int k, d_before;
    bit got, poked;
    @(negedge clk);
    mode0 = mode;
    q0.push_back('{et, ep});
    start0 = 1'b1;
    d_before = dones0;
    k = 0; got = 0; poked = 0;
    while (!got && k < 370) begin
      @(negedge clk);
      start0 = 1'b0;
      k++;
      if ((k - 1) % 20 == 0 && k <= 320) check("idx0 step", idx0, (k - 1) / 20);
      if (poke >= 0 && !poked && idx0 == poke[3:0]) begin
        start0 = 1'b1;
        poked  = 1;
      end
      if (done0) got = 1;
    end
    check("done0 latency", k, 321);
    repeat (3) @(negedge clk);
    check("done0 pulse count", dones0 - d_before, 1);
    check("tbl0 held", tbl0, et);
    check("busy0 after done", busy0, 0);
  endtask

  initial begin
    int k, bc, d_before;
    bit got;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset idx0", idx0, 0);
    check("reset busy0", busy0, 0);
    check("reset done0", done0, 0);
    check("reset tbl0", tbl0, 0);
    check("reset tbl1", tbl1, 0);
    check("reset pass0", pass0, 0);
    check("reset fail0", fail0, 0);
    rst = 1'b0;

    run0(0, 16'h6996, 1'b1, -1);
    run0(2, 16'hF000, 1'b0, 5);
    run0(3, 16'hAAAA, 1'b0, -1);

    // Abort mid-sweep at idx 7
    @(negedge clk);
    mode0 = 0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (idx0 != 4'd7 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reached idx0=7", idx0, 7);
    #2 rst = 1'b1;
    #1;
    check("async rst abcd0", {a0, b0, c0, d0}, 0);
    check("async rst idx0", idx0, 0);
    check("async rst busy0", busy0, 0);
    check("async rst tbl0", tbl0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle after rst busy0", busy0, 0);
    check("idle after rst idx0", idx0, 0);

    // HOLD_CYCLES=1, f tied high
    @(negedge clk);
    mode1 = 1;
    q1.push_back('{16'hFFFF, 1'b1});
    start1 = 1'b1;
    k = 0; bc = 0; got = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      start1 = 1'b0;
      k++;
      bc += int'(busy1);
      if (done1) got = 1;
    end
    check("done1 latency", k, 17);
    check("busy1 cycles", bc, 17);

    // start held high: back-to-back sweeps with one idle cycle
    repeat (2) @(negedge clk);
    mode1 = 4;
    q1.push_back('{16'hFF00, 1'b0});
    q1.push_back('{16'hFF00, 1'b0});
    d_before = dones1;
    start1 = 1'b1;
    k = 0;
    @(negedge clk);
    while (!done1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("first held done1", done1, 1);
    @(negedge clk);
    check("idle gap busy1", busy1, 0);
    @(negedge clk);
    check("relaunch busy1", busy1, 1);
    start1 = 1'b0;
    k = 0;
    while (!done1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("second held done1", done1, 1);
    repeat (4) @(negedge clk);
    check("held dones1 count", dones1 - d_before, 2);
    check("busy1 settled", busy1, 0);

    check("q0 drained", q0.size(), 0);
    check("q1 drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
